// File: rtl/json_int_array_tx.sv
// rtl/json_int_array_tx.sv - streams signed integers out as JSON array text.
// Define JSON_TX_SPACE_EN to add a space after each ',' separator.
module json_int_array_tx #(
    parameter int DATA_W  = 32,
    parameter int MAX_DIG = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_empty,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int SP_W = $clog2(MAX_DIG + 1);
    localparam int WIDE = DATA_W + 4;

    localparam logic [3:0] ST_START  = 4'd0;
    localparam logic [3:0] ST_OPEN   = 4'd1;
    localparam logic [3:0] ST_SIGN   = 4'd2;
    localparam logic [3:0] ST_CONV   = 4'd3;
    localparam logic [3:0] ST_EMIT   = 4'd4;
    localparam logic [3:0] ST_SEP    = 4'd5;
    localparam logic [3:0] ST_ACCEPT = 4'd6;
    localparam logic [3:0] ST_CLOSE  = 4'd7;
`ifdef JSON_TX_SPACE_EN
    localparam logic [3:0] ST_SPACE  = 4'd8;
`endif

    logic [3:0]        state_q, state_d;
    logic [DATA_W-1:0] mag_q, mag_d;
    logic              neg_q, neg_d;
    logic              last_q, last_d;
    logic              empty_q, empty_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [3:0]        stk_q [MAX_DIG];
    logic [SP_W-1:0]   sp_q;
    logic              push, pop;

    logic              hs;
    logic              in_acc;
    logic              in_neg;
    logic [DATA_W-1:0] in_mag;
    logic [WIDE-1:0]   mag_wide;
    logic [DATA_W-1:0] mag_div;
    logic [3:0]        digit;
    logic              mag_small;

    assign in_ready  = (state_q == ST_START) || (state_q == ST_ACCEPT);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_START);

    assign hs       = out_valid_q && out_ready;
    assign in_acc   = in_valid && in_ready;
    assign in_neg   = in_data[DATA_W-1];
    assign in_mag   = in_neg ? (~in_data + DATA_W'(1)) : in_data;

    // Widened so the constant 10 fits even for very narrow DATA_W.
    assign mag_wide  = {4'b0000, mag_q};
    assign mag_div   = DATA_W'(mag_wide / WIDE'(10));
    assign digit     = 4'(mag_wide % WIDE'(10));
    assign mag_small = (mag_wide < WIDE'(10));

    // The output register always holds the byte belonging to the current
    // emitting state; a handshake loads the next byte in the same cycle.
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        neg_d       = neg_q;
        last_d      = last_q;
        empty_d     = empty_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        push        = 1'b0;
        pop         = 1'b0;
        case (state_q)
            ST_START: if (in_acc) begin
                neg_d       = in_neg;
                mag_d       = in_mag;
                last_d      = in_last | in_empty;
                empty_d     = in_empty;
                out_valid_d = 1'b1;
                out_data_d  = 8'h5B;
                out_last_d  = 1'b0;
                state_d     = ST_OPEN;
            end
            ST_OPEN: if (hs) begin
                if (empty_q) begin
                    out_data_d = 8'h5D;
                    out_last_d = 1'b1;
                    state_d    = ST_CLOSE;
                end else if (neg_q) begin
                    out_data_d = 8'h2D;
                    state_d    = ST_SIGN;
                end else begin
                    out_valid_d = 1'b0;
                    state_d     = ST_CONV;
                end
            end
            ST_SIGN: if (hs) begin
                out_valid_d = 1'b0;
                state_d     = ST_CONV;
            end
            ST_CONV: begin
                // The most significant digit goes straight to the output.
                if (mag_small) begin
                    out_valid_d = 1'b1;
                    out_data_d  = 8'h30 + {4'b0000, digit};
                    state_d     = ST_EMIT;
                end else begin
                    push  = 1'b1;
                    mag_d = mag_div;
                end
            end
            ST_EMIT: if (hs) begin
                if (sp_q != '0) begin
                    pop        = 1'b1;
                    out_data_d = 8'h30 + {4'b0000, stk_q[sp_q - SP_W'(1)]};
                end else if (last_q) begin
                    out_data_d = 8'h5D;
                    out_last_d = 1'b1;
                    state_d    = ST_CLOSE;
                end else begin
                    out_data_d = 8'h2C;
                    state_d    = ST_SEP;
                end
            end
            ST_SEP: if (hs) begin
`ifdef JSON_TX_SPACE_EN
                out_data_d  = 8'h20;
                state_d     = ST_SPACE;
`else
                out_valid_d = 1'b0;
                state_d     = ST_ACCEPT;
`endif
            end
`ifdef JSON_TX_SPACE_EN
            ST_SPACE: if (hs) begin
                out_valid_d = 1'b0;
                state_d     = ST_ACCEPT;
            end
`endif
            ST_ACCEPT: if (in_acc) begin
                neg_d  = in_neg;
                mag_d  = in_mag;
                last_d = in_last;
                if (in_neg) begin
                    out_valid_d = 1'b1;
                    out_data_d  = 8'h2D;
                    state_d     = ST_SIGN;
                end else begin
                    state_d = ST_CONV;
                end
            end
            ST_CLOSE: if (hs) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                state_d     = ST_START;
            end
            default: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                state_d     = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_START;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            last_q      <= 1'b0;
            empty_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            sp_q        <= '0;
            for (int i = 0; i < MAX_DIG; i++) begin
                stk_q[i] <= 4'd0;
            end
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            last_q      <= last_d;
            empty_q     <= empty_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            if (push) begin
                stk_q[sp_q] <= digit;
                sp_q        <= sp_q + SP_W'(1);
            end else if (pop) begin
                sp_q <= sp_q - SP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_json_int_array_tx.sv
// tb/tb_json_int_array_tx.sv - self-checking bench for json_int_array_tx.
module tb_json_int_array_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_empty = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    int    errors = 0;
    int    checks = 0;
    bit    chk_en = 1'b0;
    bit    rand_ready = 1'b0;
    bit    stall_pending = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] exp_q [$];
    string rx_str = "";
    string got_str = "";

    json_int_array_tx #(.DATA_W(32), .MAX_DIG(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_str(input string name, input string got, input string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
        end
    endtask

    // Reference text of one array, built directly from the integer values.
    function automatic string golden(input longint v[$], input bit empty);
        string s = "[";
        if (!empty) begin
            foreach (v[i]) begin
`ifdef JSON_TX_SPACE_EN
                if (i > 0) s = {s, ", "};
`else
                if (i > 0) s = {s, ","};
`endif
                s = {s, $sformatf("%0d", v[i])};
            end
        end
        return {s, "]"};
    endfunction

    task automatic expect_text(input string s);
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back({(i == s.len() - 1), s[i]});
        end
    endtask

    // Compare process: every handshaken byte against the model queue, plus
    // byte stability across every stalled cycle.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (stall_pending) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_data", {56'd0, out_data}, {56'd0, prev_data});
                chk("stall_last", {63'd0, out_last}, {63'd0, prev_last});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h expected none", out_data);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("byte", {56'd0, out_data}, {56'd0, e[7:0]});
                    chk("last", {63'd0, out_last}, {63'd0, e[8]});
                end
                rx_str = $sformatf("%s%c", rx_str, out_data);
                if (out_last) begin
                    got_str = rx_str;
                    rx_str  = "";
                end
            end
            stall_pending = out_valid && !out_ready;
            prev_data     = out_data;
            prev_last     = out_last;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_elem(input longint v, input bit last, input bit empty, input bit chk_lat);
        bit done = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 32'(v);
        in_last  = last;
        in_empty = empty;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                if (chk_lat) begin
                    chk("open_latency_valid", {63'd0, out_valid}, 64'd1);
                    chk("open_latency_data", {56'd0, out_data}, 64'h5B);
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
    endtask

    task automatic send_array(input longint v[$]);
        expect_text(golden(v, 1'b0));
        foreach (v[i]) send_elem(v[i], (i == v.size() - 1), 1'b0, (i == 0));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, {63'd0, (exp_q.size() == 0 && !busy)}, 64'd1);
    endtask

    initial begin
        longint v[$];
        int n;

        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {56'd0, out_data}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        v = '{12, -3, 450};
        send_array(v);
        wait_done("arr3");
`ifdef JSON_TX_SPACE_EN
        chk_str("arr3_text", got_str, "[12, -3, 450]");
`else
        chk_str("arr3_text", got_str, "[12,-3,450]");
`endif

        v = '{0};
        send_array(v);
        wait_done("zero");
        chk_str("zero_text", got_str, "[0]");

        v = '{-64'sd2147483648};
        send_array(v);
        wait_done("minint");
        chk_str("minint_text", got_str, "[-2147483648]");
        chk("minint_len", 64'(got_str.len()), 64'd13);

        // Empty array with a stalled sink: input must stay held off.
        out_ready = 1'b0;
        expect_text("[]");
        send_elem(0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("empty_hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            if (busy) chk("empty_in_ready", {63'd0, in_ready}, 64'd0);
            n++;
        end
        wait_done("empty");
        chk_str("empty_text", got_str, "[]");

        expect_text("[]");
        send_elem(5, 1'b0, 1'b1, 1'b0);
        wait_done("empty_nolast");
        chk_str("empty_nolast_text", got_str, "[]");

        v = '{};
        for (int i = 0; i < 10; i++) v.push_back(longint'(int'($urandom)));
        rand_ready = 1'b1;
        send_array(v);
        wait_done("rand10");
        chk_str("rand10_text", got_str, golden(v, 1'b0));
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

`ifdef JSON_TX_SPACE_EN
        v = '{1, 2};
        send_array(v);
        wait_done("space");
        chk_str("space_text", got_str, "[1, 2]");
`endif

        v = '{987654};
        send_array(v);
        n = 0;
        while (rx_str.len() < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_str("pre_reset_text", rx_str, "[98");
        chk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out_data", {56'd0, out_data}, 64'd0);
        chk("mid_rst_out_last", {63'd0, out_last}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        exp_q.delete();
        rx_str        = "";
        got_str       = "";
        stall_pending = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        v = '{7};
        send_array(v);
        wait_done("after_rst");
        chk_str("after_rst_text", got_str, "[7]");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
